// File: rtl/t2mi_frame_scheduler_pkg.sv
// Shared constants for the T2-MI frame scheduler: FSM encodings, packer state codes
// and the per-frame packet target helper.
package t2mi_frame_scheduler_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_WAIT_TICK = 2'd2;

  localparam logic [3:0] PK_HDR = 4'h0;
  localparam logic [3:0] PK_CRC = 4'h7;

  // Timestamp packet plus L1 packet follow the BB frames in every cycle.
  localparam int FRAME_OVERHEAD = 2;

  function automatic logic [11:0] frame_target(input logic [9:0] num_blocks);
    logic [11:0] blocks;
    blocks = (num_blocks == 10'd0) ? 12'd1 : {2'b00, num_blocks};
    return blocks + 12'(FRAME_OVERHEAD);
  endfunction

endpackage

// File: rtl/t2mi_frame_scheduler_if.sv
// Configuration, packer-monitor and status signals between the control/packer side
// (master) and the frame scheduler (slave).
interface t2mi_frame_scheduler_if #(
  parameter int TIMER_W = 24,
  parameter int STAT_W  = 8
);
  logic               enable;
  logic [TIMER_W-1:0] frame_period;
  logic [9:0]         plp_num_blocks;
  logic [3:0]         state_mon;
  logic               in_fifo_empty;
  logic               out_almost_full;
  logic               clr_status;

  logic               ENA_TS2T2MI;
  logic               frame_tick;
  logic               frame_done;
  logic [11:0]        pkt_in_frame;
  logic               overrun;
  logic [STAT_W-1:0]  overrun_cnt;
  logic               underrun;

  modport master (
    output enable, frame_period, plp_num_blocks, state_mon,
           in_fifo_empty, out_almost_full, clr_status,
    input  ENA_TS2T2MI, frame_tick, frame_done, pkt_in_frame,
           overrun, overrun_cnt, underrun
  );

  modport slave (
    input  enable, frame_period, plp_num_blocks, state_mon,
           in_fifo_empty, out_almost_full, clr_status,
    output ENA_TS2T2MI, frame_tick, frame_done, pkt_in_frame,
           overrun, overrun_cnt, underrun
  );
endinterface

// File: rtl/t2mi_frame_scheduler_timer.sv
// Reloadable frame-period down-counter; ticks when it reaches zero while enabled.
module t2mi_frame_timer #(
  parameter int TIMER_W = 24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable_i,
  input  logic [TIMER_W-1:0] frame_period_i,
  output logic               tick_o
);

  logic [TIMER_W-1:0] timer_q, timer_d, reload;

  // Holding at zero while disabled makes the first enabled cycle tick immediately.
  always_comb begin
    reload  = (frame_period_i < TIMER_W'(2)) ? TIMER_W'(1) : frame_period_i - TIMER_W'(1);
    timer_d = timer_q;
    if (!enable_i)
      timer_d = '0;
    else if (timer_q == '0)
      timer_d = reload;
    else
      timer_d = timer_q - TIMER_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end

  assign tick_o = RST && enable_i && (timer_q == '0);

endmodule

// File: rtl/t2mi_frame_scheduler.sv
// Paces the T2-MI packer to one frame cycle (BB frames + timestamp + L1) per T2 frame,
// gating ENA_TS2T2MI and reporting overrun/underrun.
module t2mi_frame_scheduler
  import t2mi_frame_scheduler_pkg::*;
#(
  parameter int TIMER_W        = 24,
  parameter int UNDERRUN_LIMIT = 4096,
  parameter int STAT_W         = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  t2mi_frame_scheduler_if.slave  bus
);

  localparam int UR_W = $clog2(UNDERRUN_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic              pend_q, pend_d;
  logic [11:0]       pkt_q, pkt_d;
  logic [3:0]        prev_state_q;
  logic              ov_q, ov_d;
  logic [STAT_W-1:0] ovcnt_q, ovcnt_d;
  logic              ur_q, ur_d;
  logic [UR_W-1:0]   urcnt_q, urcnt_d;

  logic        tick, pkt_end, in_run, last_end, ena, ov_event, starving;
  logic [11:0] target;

  t2mi_frame_timer #(.TIMER_W(TIMER_W)) u_timer (
    .CLK            (CLK),
    .RST            (RST),
    .enable_i       (bus.enable),
    .frame_period_i (bus.frame_period),
    .tick_o         (tick)
  );

  assign target   = frame_target(bus.plp_num_blocks);
  assign pkt_end  = (prev_state_q == PK_CRC) && (bus.state_mon == PK_HDR);
  assign in_run   = (state_q == ST_RUN);
  assign last_end = in_run && pkt_end && (pkt_q == target - 12'd1);
  // Dropping ENA on the final packet end freezes the packer at header byte 0.
  assign ena      = in_run && !bus.out_almost_full && !last_end;
  assign starving = ena && bus.in_fifo_empty;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pkt_d    = pkt_q;
    ov_event = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (last_end) begin
          pkt_d  = '0;
          pend_d = 1'b0;
          // A tick landing on the last packet end starts the next cycle directly.
          if (!((tick || pend_q) && bus.enable))
            state_d = bus.enable ? ST_WAIT_TICK : ST_IDLE;
        end else begin
          if (pkt_end)
            pkt_d = pkt_q + 12'd1;
          if (tick) begin
            pend_d   = 1'b1;
            ov_event = 1'b1;
          end
        end
      end
      ST_WAIT_TICK: begin
        if (tick)
          state_d = ST_RUN;
        else if (!bus.enable)
          state_d = ST_IDLE;
      end
      default: begin
        if (tick) begin
          state_d = ST_RUN;
          pkt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    ov_d    = bus.clr_status ? 1'b0 : ov_q;
    ovcnt_d = bus.clr_status ? '0 : ovcnt_q;
    ur_d    = bus.clr_status ? 1'b0 : ur_q;
    if (ov_event) begin
      ov_d = 1'b1;
      if (ovcnt_d != '1)
        ovcnt_d = ovcnt_d + STAT_W'(1);
    end
    urcnt_d = '0;
    if (starving)
      urcnt_d = (urcnt_q == UR_W'(UNDERRUN_LIMIT)) ? urcnt_q : urcnt_q + UR_W'(1);
    // Only the transition onto the limit is an event, so a cleared flag stays clear.
    if (starving && urcnt_q == UR_W'(UNDERRUN_LIMIT - 1))
      ur_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      pkt_q        <= '0;
      prev_state_q <= PK_HDR;
      ov_q         <= 1'b0;
      ovcnt_q      <= '0;
      ur_q         <= 1'b0;
      urcnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pkt_q        <= pkt_d;
      prev_state_q <= bus.state_mon;
      ov_q         <= ov_d;
      ovcnt_q      <= ovcnt_d;
      ur_q         <= ur_d;
      urcnt_q      <= urcnt_d;
    end
  end

  assign bus.ENA_TS2T2MI  = ena;
  assign bus.frame_tick   = tick;
  assign bus.frame_done   = last_end;
  assign bus.pkt_in_frame = pkt_q;
  assign bus.overrun      = ov_q;
  assign bus.overrun_cnt  = ovcnt_q;
  assign bus.underrun     = ur_q;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Randomized bench for t2mi_frame_scheduler: a packer emulator drives state_mon and a
// frame-level reference model predicts every output each cycle.
module tb_t2mi_frame_scheduler;

  localparam int TIMER_W        = 24;
  localparam int UNDERRUN_LIMIT = 4096;
  localparam int STAT_W         = 4;
  localparam int OVCNT_MAX      = (1 << STAT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  t2mi_frame_scheduler_if #(.TIMER_W(TIMER_W), .STAT_W(STAT_W)) bus ();

  t2mi_frame_scheduler #(
    .TIMER_W(TIMER_W), .UNDERRUN_LIMIT(UNDERRUN_LIMIT), .STAT_W(STAT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave)
  );

  int checkCount = 0;
  int failCount  = 0;

  // stimulus knobs
  int curPeriod, curBlocks, pktLen, afPct, emptyPct, clrPct, togglePct;
  bit curEnable;
  int pktPos;

  // reference model: a frame is either in progress or not; ticks arrive every period
  bit     mInFrame, mOwed, mOv, mUr, mPrevEnable;
  int     mPkt, mOvCnt, mEmptyRun, mPrevState;
  longint mCycle, mLastTick;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int packerCode(input int pos);
    if (pos == 0) return 0;
    if (pos == pktLen - 1) return 7;
    return 3;
  endfunction

  task automatic modelReset();
    mInFrame = 0; mOwed = 0; mOv = 0; mUr = 0; mPrevEnable = 0;
    mPkt = 0; mOvCnt = 0; mEmptyRun = 0; mPrevState = 0;
    mLastTick = 0;
    pktPos = 0;
  endtask

  task automatic doReset();
    RST = 1'b0;
    curEnable = 0;
    bus.enable = 1'b0; bus.frame_period = '0; bus.plp_num_blocks = '0;
    bus.state_mon = 4'h0; bus.in_fifo_empty = 1'b0; bus.out_almost_full = 1'b0;
    bus.clr_status = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_ena",   32'(bus.ENA_TS2T2MI),  32'd0);
    checkOutput("rst_tick",  32'(bus.frame_tick),   32'd0);
    checkOutput("rst_done",  32'(bus.frame_done),   32'd0);
    checkOutput("rst_pkt",   32'(bus.pkt_in_frame), 32'd0);
    checkOutput("rst_ov",    32'(bus.overrun),      32'd0);
    checkOutput("rst_ovcnt", 32'(bus.overrun_cnt),  32'd0);
    checkOutput("rst_ur",    32'(bus.underrun),     32'd0);
    modelReset();
    RST = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bit af, empty, clr, en, tick, pe, lastEnd, ena;
      int sm, effP, target;
      if ($urandom_range(99) < togglePct) curEnable = !curEnable;
      en    = curEnable;
      sm    = packerCode(pktPos);
      af    = ($urandom_range(99) < afPct);
      empty = ($urandom_range(99) < emptyPct);
      clr   = ($urandom_range(99) < clrPct);
      bus.enable          = en;
      bus.frame_period    = TIMER_W'(curPeriod);
      bus.plp_num_blocks  = 10'(curBlocks);
      bus.state_mon       = 4'(sm);
      bus.out_almost_full = af;
      bus.in_fifo_empty   = empty;
      bus.clr_status      = clr;
      #1;
      effP    = (curPeriod < 2) ? 2 : curPeriod;
      tick    = en && (!mPrevEnable || (mCycle - mLastTick) == longint'(effP));
      pe      = (mPrevState == 7) && (sm == 0);
      target  = ((curBlocks == 0) ? 1 : curBlocks) + 2;
      lastEnd = mInFrame && pe && (mPkt == target - 1);
      ena     = mInFrame && !af && !lastEnd;

      checkOutput("ena",   32'(bus.ENA_TS2T2MI),  32'(ena));
      checkOutput("tick",  32'(bus.frame_tick),   32'(tick));
      checkOutput("done",  32'(bus.frame_done),   32'(lastEnd));
      checkOutput("pkt",   32'(bus.pkt_in_frame), 32'(mPkt));
      checkOutput("ov",    32'(bus.overrun),      32'(mOv));
      checkOutput("ovcnt", 32'(bus.overrun_cnt),  32'(mOvCnt));
      checkOutput("ur",    32'(bus.underrun),     32'(mUr));

      if (clr) begin mOv = 0; mOvCnt = 0; mUr = 0; end
      if (mInFrame) begin
        if (lastEnd) begin
          mPkt = 0;
          if (!((tick || mOwed) && en)) mInFrame = 0;
          mOwed = 0;
        end else begin
          if (pe) mPkt++;
          if (tick) begin
            mOwed = 1; mOv = 1;
            if (mOvCnt < OVCNT_MAX) mOvCnt++;
          end
        end
      end else if (tick) begin
        mInFrame = 1; mPkt = 0;
      end
      if (ena && empty) begin
        mEmptyRun++;
        if (mEmptyRun == UNDERRUN_LIMIT) mUr = 1;
      end else begin
        mEmptyRun = 0;
      end
      if (tick) mLastTick = mCycle;
      mPrevEnable = en;
      mPrevState  = sm;
      mCycle++;
      if (ena) pktPos = (pktPos + 1) % pktLen;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic startSegment(input int p, input int nb, input int len, input int af,
                              input int empty, input int clr, input int tog);
    curEnable = 0; togglePct = 0;
    curPeriod = p; curBlocks = nb; afPct = af; emptyPct = empty; clrPct = clr;
    applyStimulus(1);
    pktLen = len; pktPos = pktPos % pktLen;
    curEnable = 1; togglePct = tog;
  endtask

  initial begin
    mCycle = 0; pktLen = 120;
    curPeriod = 1000; curBlocks = 3; afPct = 0; emptyPct = 0; clrPct = 0; togglePct = 0;
    doReset();

    // on-time frames, then late frames, then a 50-cycle backpressure burst
    startSegment(1000, 3, 120, 0, 0, 0, 0);  applyStimulus(2500);
    startSegment(1000, 3, 260, 0, 0, 0, 0);  applyStimulus(3000);
    startSegment(1000, 3, 120, 0, 0, 0, 0);  applyStimulus(300);
    afPct = 100; applyStimulus(50);
    afPct = 0;   applyStimulus(900);

    // tick coincident with every last packet end
    startSegment(601, 3, 120, 0, 0, 0, 0);   applyStimulus(2500);

    // enable dropped after packet 2
    startSegment(1000, 3, 120, 0, 0, 0, 0);  applyStimulus(250);
    curEnable = 0; applyStimulus(1200);

    // overrun counter saturation with the minimum period
    startSegment(1, 3, 40, 0, 0, 0, 0);      applyStimulus(200);
    clrPct = 100; applyStimulus(1); clrPct = 0; applyStimulus(30);

    for (int s = 0; s < 8; s++) begin
      startSegment(int'($urandom_range(400, 30)), int'($urandom_range(4, 0)),
                   int'($urandom_range(40, 3)), 10, 30, 2, 1);
      applyStimulus(1500);
    end
    doReset();

    // long starvation inside one frame, then a clear
    startSegment(20000, 300, 20, 0, 100, 0, 0); applyStimulus(4300);
    clrPct = 100; applyStimulus(1); clrPct = 0; applyStimulus(20);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
